// File: rtl/fp_divider.sv
// Iterative binary32 divider, c = a / b.
// Restoring mantissa division produces one quotient bit per cycle. The
// latency is fixed: PREP takes 1 cycle, DIV takes 25 and NORM takes 1.
// Special operands still run the full DIV phase, and NORM replaces its result.
// Denormal operands are flushed to zero.
module fp_divider #(
  parameter int N     = 32,
  parameter int QBITS = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         overflow,
  output logic         underflow,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, NORM} state_t;

  state_t state_q, state_d;

  logic [31:0]       aOp_q, bOp_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       div_q;
  logic [24:0]       rem_q;
  logic [QBITS-1:0]  quot_q;
  logic [4:0]        cnt_q;
  logic              spec_q;
  logic [31:0]       specVal_q;
  logic              specDz_q;
  logic [31:0]       c_q;
  logic              done_q, ovf_q, unf_q, dbz_q;

  logic [7:0]  expA, expB;
  logic [22:0] fracA, fracB;
  logic        aZero, bZero, aInf, bInf, aNan, bNan, sgn;
  logic        specHit, specDz;
  logic [31:0] specVal;
  logic [24:0] remDiff;
  logic        remGe;
  logic signed [9:0] expNorm;
  logic [22:0] mantNorm;
  logic [31:0] resC;
  logic        resOv, resUn, resDz;

  assign expA  = aOp_q[30:23];
  assign expB  = bOp_q[30:23];
  assign fracA = aOp_q[22:0];
  assign fracB = bOp_q[22:0];
  assign aZero = (expA == 8'h00);
  assign bZero = (expB == 8'h00);
  assign aInf  = (expA == 8'hFF) && (fracA == 23'd0);
  assign bInf  = (expB == 8'hFF) && (fracB == 23'd0);
  assign aNan  = (expA == 8'hFF) && (fracA != 23'd0);
  assign bNan  = (expB == 8'hFF) && (fracB != 23'd0);
  assign sgn   = aOp_q[31] ^ bOp_q[31];

  assign remDiff = rem_q - {1'b0, div_q};
  assign remGe   = (rem_q >= {1'b0, div_q});

  // State register. It advances only when the clock enable is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DIV runs until the bit counter has reached zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = DIV;
      DIV:     if (cnt_q == 5'd0) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. busy is high in every state except IDLE.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Special-operand classification. The checks are in priority order, so the first match wins.
  always_comb begin
    specHit = 1'b1;
    specDz  = 1'b0;
    specVal = 32'h7FC00000;
    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
      specVal = 32'h7FC00000;
      specDz  = aZero && bZero;
    end else if (bZero) begin
      specVal = {sgn, 8'hFF, 23'd0};
      specDz  = 1'b1;
    end else if (aInf) begin
      specVal = {sgn, 8'hFF, 23'd0};
    end else if (aZero || bInf) begin
      specVal = {sgn, 31'd0};
    end else begin
      specHit = 1'b0;
    end
  end

  // Normalise the quotient, apply the range checks, and let special cases override the result.
  always_comb begin
    if (quot_q[QBITS-1]) begin
      mantNorm = quot_q[23:1];
      expNorm  = exp_q;
    end else begin
      mantNorm = quot_q[22:0];
      expNorm  = exp_q - 10'sd1;
    end
    resC  = {sign_q, expNorm[7:0], mantNorm};
    resOv = 1'b0;
    resUn = 1'b0;
    resDz = 1'b0;
    if (spec_q) begin
      resC  = specVal_q;
      resDz = specDz_q;
    end else if (expNorm >= 10'sd255) begin
      resC  = {sign_q, 8'hFF, 23'd0};
      resOv = 1'b1;
    end else if (expNorm <= 10'sd0) begin
      resC  = {sign_q, 31'd0};
      resUn = 1'b1;
    end
  end

  // Datapath registers: operand capture, setup, the restoring-division step, and the result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      aOp_q     <= '0;
      bOp_q     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      spec_q    <= 1'b0;
      specVal_q <= '0;
      specDz_q  <= 1'b0;
      c_q       <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            aOp_q <= a;
            bOp_q <= b;
          end
        end
        PREP: begin
          sign_q    <= sgn;
          exp_q     <= $signed({2'b00, expA}) - $signed({2'b00, expB}) + 10'sd127;
          div_q     <= {1'b1, fracB};
          rem_q     <= {2'b01, fracA};
          cnt_q     <= 5'(QBITS - 1);
          spec_q    <= specHit;
          specVal_q <= specVal;
          specDz_q  <= specDz;
        end
        DIV: begin
          if (remGe) begin
            rem_q <= remDiff << 1;
          end else begin
            rem_q <= rem_q << 1;
          end
          quot_q <= {quot_q[QBITS-2:0], remGe};
          cnt_q  <= cnt_q - 5'd1;
        end
        NORM: begin
          c_q    <= resC;
          ovf_q  <= resOv;
          unf_q  <= resUn;
          dbz_q  <= resDz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done        = done_q;
  assign c           = c_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider. It runs directed cases from the
// design's worked examples, then randomized operands compared against an
// integer-division reference model.
module tb_fp_divider;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] c;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  fp_divider #(.N(32), .QBITS(25)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .c          (c),
    .overflow   (overflow),
    .underflow  (underflow),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison, and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference quotient built from the IEEE rules with plain integer division.
  function automatic void refDiv(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rc, output logic [2:0] rf);
    int ea, eb, e;
    longint unsigned ma, mb, q, m;
    logic xz, yz, xi, yi, xn, yn, s;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    xz = (ea == 0);
    yz = (eb == 0);
    xi = (ea == 255) && (x[22:0] == 0);
    yi = (eb == 255) && (y[22:0] == 0);
    xn = (ea == 255) && (x[22:0] != 0);
    yn = (eb == 255) && (y[22:0] != 0);
    s  = x[31] ^ y[31];
    rf = 3'b000;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      rc = 32'h7FC00000;
      rf[0] = xz && yz;
    end else if (yz) begin
      rc = {s, 8'hFF, 23'd0};
      rf[0] = 1'b1;
    end else if (xi) begin
      rc = {s, 8'hFF, 23'd0};
    end else if (xz || yi) begin
      rc = {s, 31'd0};
    end else begin
      ma = 64'h800000 + longint'(x[22:0]);
      mb = 64'h800000 + longint'(y[22:0]);
      q  = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (q >= 64'h1000000) begin
        m = (q >> 1) & 64'h7FFFFF;
      end else begin
        m = q & 64'h7FFFFF;
        e = e - 1;
      end
      if (e >= 255) begin
        rc = {s, 8'hFF, 23'd0};
        rf[2] = 1'b1;
      end else if (e <= 0) begin
        rc = {s, 31'd0};
        rf[1] = 1'b1;
      end else begin
        rc = {s, e[7:0], m[22:0]};
      end
    end
  endfunction

  // Issue one operation and wait for done.
  // The optional stall drops en, and the optional inject pulses a stray start.
  task automatic applyStimulus(input logic [31:0] ai, input logic [31:0] bi,
                               input int stallAt, input int stallLen, input int injectAt,
                               output int lat, output int busyCnt);
    @(negedge clk);
    a     = ai;
    b     = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
    lat     = 0;
    busyCnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      if (stallLen > 0 && lat == stallAt) en = 1'b0;
      if (stallLen > 0 && lat == stallAt + stallLen) en = 1'b1;
      if (lat == injectAt) begin
        start = 1'b1;
        a     = 32'h41200000;
        b     = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy) busyCnt++;
    end
    en    = 1'b1;
    start = 1'b0;
  endtask

  // Generate a random binary32 operand, weighted toward normal numbers.
  function automatic logic [31:0] randFp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2:       v[30:23] = 8'hFF;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  logic [31:0] dirA [7] = '{32'h40C00000, 32'hBF800000, 32'h3F800000, 32'h7F000000,
                            32'h00800000, 32'h40A00000, 32'h00000000};
  logic [31:0] dirB [7] = '{32'h40000000, 32'h3F000000, 32'h40400000, 32'h3E800000,
                            32'h40000000, 32'h00000000, 32'h00000000};
  logic [31:0] dirC [7] = '{32'h40400000, 32'hC0000000, 32'h3EAAAAAA, 32'h7F800000,
                            32'h00000000, 32'h7F800000, 32'h7FC00000};
  logic [2:0]  dirF [7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001};

  // Main sequence: reset, directed cases, handshake corner cases, then random operands.
  initial begin
    int lat, bc, pulses;
    logic [31:0] ra, rb, ec, firstC;
    logic [2:0]  ef;

    rst   = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_c", c, 32'h0);
    checkOutput("reset_ctl", {28'd0, busy, done, overflow, underflow}, 32'h0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'h0);
    rst = 1'b0;

    // Directed cases. Cases 1 and 2 run back to back, so 1.0/3.0 starts the cycle after done.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(dirA[i], dirB[i], -1, 0, -1, lat, bc);
      checkOutput($sformatf("dir%0d_lat", i), lat, 27);
      checkOutput($sformatf("dir%0d_busy", i), bc, 27);
      checkOutput($sformatf("dir%0d_c", i), c, dirC[i]);
      checkOutput($sformatf("dir%0d_flags", i), {29'd0, overflow, underflow, div_by_zero}, {29'd0, dirF[i]});
    end

    // A stray start five cycles into an operation is ignored.
    applyStimulus(32'h40C00000, 32'h40000000, -1, 0, 5, lat, bc);
    checkOutput("inject_lat", lat, 27);
    checkOutput("inject_c", c, 32'h40400000);
    pulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    checkOutput("inject_no_extra", pulses, 0);
    checkOutput("inject_c_held", c, 32'h40400000);

    // Ten stalled cycles in the middle of DIV.
    applyStimulus(32'h3F800000, 32'h40400000, 6, 10, -1, lat, bc);
    checkOutput("stall_lat", lat, 37);
    checkOutput("stall_c", c, 32'h3EAAAAAA);

    // Reset in the middle of DIV aborts the operation, and no result is produced.
    @(negedge clk);
    a     = 32'h40C00000;
    b     = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy_done", {30'd0, busy, done}, 32'h0);
    checkOutput("midrst_c", c, 32'h0);
    checkOutput("midrst_flags", {29'd0, overflow, underflow, div_by_zero}, 32'h0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput("midrst_no_done", pulses, 0);
    applyStimulus(32'hBF800000, 32'h3F000000, -1, 0, -1, lat, bc);
    checkOutput("postrst_lat", lat, 27);
    checkOutput("postrst_c", c, 32'hC0000000);

    // Random operands compared against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra = randFp();
      rb = randFp();
      refDiv(ra, rb, ec, ef);
      applyStimulus(ra, rb, -1, 0, -1, lat, bc);
      firstC = c;
      checkOutput($sformatf("rnd%0d_lat", i), lat, 27);
      checkOutput($sformatf("rnd%0d_c(%h/%h)", i, ra, rb), firstC, ec);
      checkOutput($sformatf("rnd%0d_flags", i), {29'd0, overflow, underflow, div_by_zero}, {29'd0, ef});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Iterative IEEE-754 single-precision divider, c = a / b; the inverse operation of the team's fp_multiplier.
- Shares the arithmetic datapath and the same clk/rst/en conventions.
- Uses restoring mantissa division, one quotient bit per cycle, with a start/done handshake and fixed latency.
- Flags overflow, underflow and divide-by-zero. Denormals are flushed to zero.

Parameters:
- N, 32, operand/result width. Only 32 (binary32) is supported.
- QBITS, 25, quotient bits generated by the DIV phase (1 integer + 24 fraction).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable. When 0, FSM, counters and outputs hold.
- start  input  1  request; sampled only in IDLE with en=1.
- a  input  N  dividend, binary32.
- b  input  N  divisor, binary32.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when c and the flags are valid.
- c  output  N  quotient; holds until the next done.
- overflow  output  1  result exponent >= 255; valid and held with c.
- underflow  output  1  result exponent <= 0; valid and held with c.
- div_by_zero  output  1  b is zero (or denormal) and a is not NaN; valid and held with c.

Behaviour:
- Reset: synchronous, active-high. On the edge with rst=1: state=IDLE; c=0, done=0, busy=0, overflow=0, underflow=0, div_by_zero=0. rst overrides en and any operation in progress. No result is produced for an aborted operation.
- FSM states:
  - IDLE: on start & en, register a and b, go to PREP.
  - PREP: compute sign = a[31]^b[31], exponent e = ea - eb + 127 as 10-bit signed, ma = {1,fa}, mb = {1,fb}, special-case class. Load remainder = ma, cnt = 24. Go to DIV.
  - DIV, 25 cycles, cnt 24..0: if r >= mb then q[cnt]=1 and r = r - mb, else q[cnt]=0; then r = r << 1. Go to NORM when cnt = 0.
  - NORM:
    - If q[24]=1, mantissa = q[23:1] and e is unchanged.
    - Otherwise mantissa = q[22:0] and e = e - 1.
    - Rounding is truncation (toward zero).
    - Write c and the flags, pulse done, return to IDLE.
- Latency: start sampled at edge k gives done=1 after edge k+27 (PREP 1 + DIV 25 + NORM 1). Latency is fixed for all inputs, including special cases: the DIV phase still runs and its result is overridden in NORM. Stalls from en=0 add cycles one-for-one.
- A back-to-back start is accepted in the IDLE cycle after done. start while busy is ignored and not queued.
- Operand changes on a and b after the start cycle have no effect.
- Exponent 0 is treated as zero. Special cases, in priority order:
  1. a or b NaN, 0/0, or Inf/Inf: c = 0x7FC00000. div_by_zero=1 only for 0/0.
  2. b zero with a finite nonzero or Inf: c = {sign, 0xFF, 0}, div_by_zero=1.
  3. a Inf: c = {sign, 0xFF, 0}.
  4. a zero or b Inf: c = {sign, 31'b0}.
- Range checks after normalisation:
  - e >= 255: c = {sign, 0xFF, 0}, overflow=1.
  - e <= 0: c = {sign, 31'b0}, underflow=1.
- Flags are not sticky; each done rewrites all three.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0), start pulse with en=1: done exactly 27 cycles later, c=0x40400000, all flags 0, busy high for 27 cycles.
- 0xBF800000 / 0x3F000000 (-1.0/0.5): c=0xC0000000. Then 0x3F800000 / 0x40400000 (1.0/3.0): c=0x3EAAAAAA (truncated).
- Range and zero cases:
  - 0x7F000000 / 0x3E800000 gives c=0x7F800000, overflow=1.
  - 0x00800000 / 0x40000000 gives c=0x00000000, underflow=1.
  - 0x40A00000 / 0x00000000 gives c=0x7F800000, div_by_zero=1.
  - 0x00000000 / 0x00000000 gives c=0x7FC00000, div_by_zero=1.
- Second start pulse with different operands 5 cycles into an operation: ignored. The first result is unchanged and no extra done pulse occurs. A start issued the cycle after done is accepted.
- en=0 held for 10 cycles mid-DIV: done is delayed by exactly 10 cycles, and c is the same as in the unstalled run.
- rst=1 for one cycle mid-DIV: the next edge gives IDLE with all outputs 0 and no done pulse. A new start then completes normally in 27 cycles.
